div_datapath: RTL
=================

// Module: div_datapath
// PURPOSE
// Arithmetic datapath paired with the divider control FSM: a DW-bit restoring divider,
// one quotient bit per clock. Consumes the FSM strobes (enb_sync_rst, enb_mux, enb_reg,
// enb_ready, enb_count) and returns count_flag. Holds the operands, iteration counter and
// result registers, and presents quotient/remainder plus status to the MDR top level.
// PARAMETERS
// DW  16  operand/result width (>=4)
// CW  8   width of completed-operation counter op_count_o
// PORTS
// clk           in   1    system clock, rising edge
// rst           in   1    asynchronous reset, active-low
// dividend_i    in   DW   dividend, sampled while enb_sync_rst=1
// divisor_i     in   DW   divisor, sampled while enb_sync_rst=1
// signed_i      in   1    1=two's-complement operands, sampled with operands
// enb_sync_rst  in   1    clear working regs, load operands, counter:=DW
// enb_mux       in   1    iterate select (1=iterate path, 0=hold)
// enb_reg       in   1    working-register write enable
// enb_ready     in   1    commit working result to output regs
// enb_count     in   1    increment op_count_o
// count_flag    out  1    1 while iterations remain (counter!=0), combinational from counter
// quotient_o    out  DW   committed quotient
// remainder_o   out  DW   committed remainder
// ready_o       out  1    one-cycle pulse, result committed
// div_zero_o    out  1    committed op had divisor==0 (held until next commit)
// ovf_o         out  1    committed op was signed MIN/-1 (held until next commit)
// op_count_o    out  CW   completed ops, saturates at 2^CW-1
// BEHAVIOUR
// - rst=0: every register 0 -> all outputs 0, count_flag=0; effective immediately.
// - Priority per edge: enb_sync_rst > iterate > hold.
// - enb_sync_rst=1: rem:=0; quo:=|dividend| (magnitude if signed_i, else raw); dmag:=|divisor|;
//   counter:=DW; latch neg_q = signed_i & (sign(a)^sign(b)), neg_r = signed_i & sign(a),
//   zero flag, ovf flag (signed_i & a==MIN & b==all-ones).
// - Iterate when enb_mux & enb_reg & counter!=0: {rem,quo}<<=1; t = rem_shifted - dmag
//   (DW+1 bits); if t>=0 rem:=t, quo[0]:=1; counter:=counter-1. Counter==0: regs hold.
// - count_flag=(counter!=0): high from edge after enb_sync_rst through DW iterations;
//   FSM sees 0 in the cycle after the last iteration (no iteration occurs in that cycle).
// - enb_ready=1 at edge: quotient_o := zero ? all-ones : (neg_q ? -quo : quo);
//   remainder_o := zero ? dividend (as sampled) : (neg_r ? -rem : rem); ovf case forces
//   quotient_o=MIN, remainder_o=0; div_zero_o/ovf_o updated; ready_o=1 next cycle only.
// - enb_count=1: op_count_o+=1 unless saturated. Same-cycle enb_ready & enb_count both apply.
// - Outputs hold between commits; new enb_sync_rst does not disturb quotient_o/remainder_o.
// - enb_sync_rst mid-iteration: restarts cleanly with new operands, counter:=DW.
// - Latency (FSM order sync_rst, setup, DW+1 process, save): ready_o 1 cycle after save cycle.
// - Division by zero runs full DW iterations (no early exit); result overridden at commit.
// TESTING
// DW=16. Unsigned 100/7 -> quotient_o=14, remainder_o=2, ready_o 1-cycle pulse, flags 0.
// Signed -100/7 -> quotient_o=0xFFF2, remainder_o=0xFFFE; signed 100/-7 -> 0xFFF2, 0x0002.
// 5/0 -> quotient_o=0xFFFF, remainder_o=5, div_zero_o=1; next 9/3 clears it (q=3, r=0).
// Signed 0x8000/0xFFFF -> quotient_o=0x8000, remainder_o=0, ovf_o=1; unsigned same -> q=0, r=0x8000.
// count_flag high exactly 16 cycles after sync_rst; rst low mid-iteration -> all outputs 0 at once.
// enb_count pulsed 260 times with CW=8 -> op_count_o saturates at 255; random 1k ops vs model.

Source files
------------

// File: rtl/div_datapath.sv
// Restoring divider datapath: one quotient bit per clock, driven by the
// divider control FSM strobes; holds operands, iteration counter and results.
module div_datapath #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    input  logic          signed_i,
    input  logic          enb_sync_rst,
    input  logic          enb_mux,
    input  logic          enb_reg,
    input  logic          enb_ready,
    input  logic          enb_count,
    output logic          count_flag,
    output logic [DW-1:0] quotient_o,
    output logic [DW-1:0] remainder_o,
    output logic          ready_o,
    output logic          div_zero_o,
    output logic          ovf_o,
    output logic [CW-1:0] op_count_o
);

    localparam int NW = $clog2(DW + 1);
    localparam logic [NW-1:0] CNT_INIT = NW'(DW);
    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW - 1){1'b0}}};

    logic [DW-1:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d, dvd_q, dvd_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic          zero_q, zero_d, ovf_q, ovf_d;
    logic [DW-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic          ready_q, ready_d, div_zero_q, div_zero_d, ovf_out_q, ovf_out_d;
    logic [CW-1:0] op_count_q, op_count_d;

    logic          a_neg, b_neg, iterate;
    logic [DW:0]   shifted, diff;

    assign count_flag = (cnt_q != '0);
    assign a_neg      = signed_i & dividend_i[DW-1];
    assign b_neg      = signed_i & divisor_i[DW-1];
    assign iterate    = enb_mux & enb_reg & count_flag;
    assign shifted    = {rem_q, quo_q[DW-1]};
    assign diff       = shifted - {1'b0, dmag_q};

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        dvd_d       = dvd_q;
        cnt_d       = cnt_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ovf_out_d   = ovf_out_q;
        op_count_d  = op_count_q;
        ready_d     = enb_ready;

        if (enb_sync_rst) begin
            rem_d   = '0;
            quo_d   = a_neg ? -dividend_i : dividend_i;
            dmag_d  = b_neg ? -divisor_i : divisor_i;
            dvd_d   = dividend_i;
            cnt_d   = CNT_INIT;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            zero_d  = (divisor_i == '0);
            ovf_d   = signed_i & (dividend_i == MIN_VAL) & (divisor_i == '1);
        end else if (iterate) begin
            // Top bit of the DW+1 difference is the borrow: clear means t >= 0.
            if (!diff[DW]) begin
                rem_d = diff[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
                rem_d = shifted[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q - NW'(1);
        end

        if (enb_ready) begin
            div_zero_d = zero_q;
            ovf_out_d  = ovf_q;
            if (zero_q) begin
                quotient_d  = '1;
                remainder_d = dvd_q;
            end else if (ovf_q) begin
                quotient_d  = MIN_VAL;
                remainder_d = '0;
            end else begin
                quotient_d  = neg_q_q ? -quo_q : quo_q;
                remainder_d = neg_r_q ? -rem_q : rem_q;
            end
        end

        if (enb_count && (op_count_q != '1)) begin
            op_count_d = op_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dmag_q      <= '0;
            dvd_q       <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_out_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            dvd_q       <= dvd_d;
            cnt_q       <= cnt_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            div_zero_q  <= div_zero_d;
            ovf_out_q   <= ovf_out_d;
            op_count_q  <= op_count_d;
        end
    end

    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign ready_o     = ready_q;
    assign div_zero_o  = div_zero_q;
    assign ovf_o       = ovf_out_q;
    assign op_count_o  = op_count_q;

endmodule
